// File: rtl/axis_out.sv
// AXI-Stream output stage: result FIFO, frame tlast and ap_done generation.
// Optional stall/extra-sample overflow flag enabled by AXIS_OUT_OVF_CHECK_EN.
module axis_out #(
  parameter int pDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int pLEN_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ap_start,
  input  logic [pLEN_WIDTH-1:0]  data_length,
  input  logic [pDATA_WIDTH-1:0] fir_data,
  input  logic                   fir_valid,
  output logic                   fir_ready,
  output logic                   outfinish,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   ap_done,
  output logic                   ovf_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_q;
  logic [pLEN_WIDTH-1:0]  len_q;
  logic [pLEN_WIDTH-1:0]  rx_cnt_q;
  logic [pLEN_WIDTH-1:0]  tx_cnt_q;
  logic [pLEN_WIDTH-1:0]  rx_cnt_d;
  logic [pLEN_WIDTH-1:0]  last_idx;

  logic [pDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          free;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic is_idle;

  assign is_idle   = (state_q == IDLE);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign free      = CW'(FIFO_DEPTH) - cnt_q;

  assign fir_ready = (state_q == RUN) & ~full;
  assign push      = fir_valid & fir_ready;
  assign sm_tvalid = ~empty;
  assign pop       = sm_tvalid & sm_tready;
  assign sm_tdata  = sm_tvalid ? mem_q[rd_ptr_q] : '0;

  // len_q-1 only matters when len_q is non-zero
  assign last_idx  = len_q - pLEN_WIDTH'(1);
  assign sm_tlast  = sm_tvalid & (len_q != '0) & (tx_cnt_q == last_idx);

  assign outfinish = (free >= CW'(2)) | is_idle;
  assign ap_done   = (state_q == DONE);
  assign rx_cnt_d  = rx_cnt_q + pLEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fir_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (pop) tx_cnt_q <= tx_cnt_q + pLEN_WIDTH'(1);
      unique case (state_q)
        IDLE: begin
          if (ap_start) begin
            len_q    <= data_length;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            state_q  <= (data_length == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (push) begin
            rx_cnt_q <= rx_cnt_d;
            if (rx_cnt_d == len_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && sm_tlast) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AXIS_OUT_OVF_CHECK_EN
  logic [6:0] wd_q;
  logic       ovf_q;
  logic       stall;
  logic       extra;

  assign stall   = fir_valid & (state_q == RUN) & full;
  assign extra   = fir_valid & (is_idle | (state_q == DRAIN));
  assign ovf_err = ovf_q;

  // wd_q counts prior stalled cycles; saturates once past the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (!stall)     wd_q <= '0;
      else if (!wd_q[6]) wd_q <= wd_q + 7'd1;
      if (ap_start && is_idle) ovf_q <= 1'b0;
      else if ((stall && wd_q[6]) || extra) ovf_q <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_out.sv
// Scoreboard bench for axis_out: frames, backpressure, wrap, reset, overflow.
module tb_axis_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        ap_start;
  logic [9:0]  data_length;
  logic [31:0] fir_data;
  logic        fir_valid;
  logic        fir_ready;
  logic        outfinish;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready;
  logic        ap_done;
  logic        ovf_err;

`ifdef AXIS_OUT_OVF_CHECK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   done_due = -1;
  int   rdy_mode = 0;
  logic exp_last = 1'b0;

  axis_out #(
    .pDATA_WIDTH(32),
    .FIFO_DEPTH (4),
    .pLEN_WIDTH (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ap_start   (ap_start),
    .data_length(data_length),
    .fir_data   (fir_data),
    .fir_valid  (fir_valid),
    .fir_ready  (fir_ready),
    .outfinish  (outfinish),
    .sm_tvalid  (sm_tvalid),
    .sm_tdata   (sm_tdata),
    .sm_tlast   (sm_tlast),
    .sm_tready  (sm_tready),
    .ap_done    (ap_done),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       sm_tready = 1'b0;
      1:       sm_tready = 1'b1;
      default: sm_tready = ~sm_tready;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Output monitor: checks against the queue, then updates it
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() >= 4) chk("full_rdy", fir_ready, 0);
      chk("outfin", outfinish, (q.size() <= 2));
      chk("done", ap_done, (cyc == done_due));
      if (sm_tvalid) begin
        if (q.size() == 0) begin
          chk("spurious", sm_tvalid, 0);
        end else begin
          chk("tdata", sm_tdata, q[0].d);
          chk("tlast", sm_tlast, q[0].l);
          if (sm_tready) begin
            if (q[0].l) done_due = cyc + 1;
            void'(q.pop_front());
          end
        end
      end else begin
        chk("valid", sm_tvalid, (q.size() != 0));
        chk("idle_out", {sm_tdata[30:0], sm_tlast}, 0);
      end
      if (fir_valid && fir_ready)
        q.push_back('{d: fir_data, l: exp_last});
    end
  end

  task automatic start_frame(input int len);
    ap_start    = 1'b1;
    data_length = 10'(len);
    if (len == 0) done_due = cyc + 1;
    @(posedge clk); #1;
    ap_start = 1'b0;
  endtask

  task automatic push_samples(input int n, input int base,
                              input int idx0, input int len);
    for (int i = 0; i < n; i++) begin
      int t;
      fir_valid = 1'b1;
      fir_data  = 32'(base + i);
      exp_last  = ((idx0 + i) == (len - 1));
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!fir_ready && t < 300);
      if (!fir_ready) chk("push_to", fir_ready, 1);
      @(posedge clk); #1;
    end
    fir_valid = 1'b0;
    exp_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!ap_done && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("done_to", ap_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"},  fir_ready, 0);
    chk({tag, "_outf"}, outfinish, 1);
    chk({tag, "_vld"},  sm_tvalid, 0);
    chk({tag, "_data"}, sm_tdata,  0);
    chk({tag, "_last"}, sm_tlast,  0);
    chk({tag, "_done"}, ap_done,   0);
    chk({tag, "_ovf"},  ovf_err,   0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    ap_start    = 1'b0;
    data_length = '0;
    fir_data    = '0;
    fir_valid   = 1'b0;
    sm_tready   = 1'b0;
    #12;
    chk_reset_outs("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // basic frame, back-to-back pushes
    rdy_mode = 1;
    @(posedge clk); #1;
    start_frame(4);
    push_samples(4, 1, 0, 4);
    wait_done();

    // backpressure
    rdy_mode = 0;
    @(posedge clk); #1;
    start_frame(8);
    fork
      push_samples(8, 'h100, 0, 8);
      begin
        repeat (10) @(negedge clk);
        chk("bp_rdy",  fir_ready, 0);
        chk("bp_outf", outfinish, 0);
        chk("bp_vld",  sm_tvalid, 1);
        chk("bp_data", sm_tdata,  'h100);
        @(posedge clk);
        rdy_mode = 1;
      end
    join
    wait_done();

    // zero length
    start_frame(0);
    chk("zero_vld", sm_tvalid, 0);
    wait_done();

    // simultaneous push/pop across pointer wrap
    rdy_mode = 2;
    start_frame(20);
    push_samples(20, 'h200, 0, 20);
    wait_done();

    // reset mid-frame
    rdy_mode = 1;
    @(posedge clk); #1;
    start_frame(5);
    push_samples(2, 'h300, 0, 5);
    repeat (3) @(posedge clk);
    #1;
    rdy_mode = 0;
    push_samples(2, 'h302, 2, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outs("mid");
    q.delete();
    done_due = -1;
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk); #1;
    start_frame(3);
    push_samples(3, 'h400, 0, 3);
    wait_done();

    // extra sample offered during DRAIN
    rdy_mode = 0;
    @(posedge clk); #1;
    start_frame(2);
    push_samples(2, 'h500, 0, 2);
    fir_valid = 1'b1;
    fir_data  = 'h5ff;
    @(posedge clk); #1;
    fir_valid = 1'b0;
    chk("ovf_set", ovf_err, EXP_OVF);
    rdy_mode = 1;
    wait_done();
    chk("ovf_hold", ovf_err, EXP_OVF);
    start_frame(0);
    chk("ovf_clr", ovf_err, 0);
    wait_done();

    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
